button_conditioner: RTL and testbench
=====================================

# button_conditioner

Conditions the four raw player push-buttons before they reach the reaction-game logic. Each input is synchronised, debounced and converted into a clean level and a single-cycle press pulse. A priority encoder reports which button (1–4) was pressed and flags simultaneous presses. The block sits between the board pins and the game FSM's `btn1..btn4` inputs.

## Interface
- `DEBOUNCE_CYCLES`, default 100_000: consecutive stable cycles required to accept a change. Default is 10 ms at 10 MHz. Minimum 1.
- `clk` input, 1 bit: system clock.
- `reset` input, 1 bit: asynchronous, active-high; clock `clk`.
- `btn_raw` input, 4 bits: raw asynchronous buttons, active-high; bit 0 = button 1.
- `btn_level` output, 4 bits: debounced button levels.
- `btn_pulse` output, 4 bits: one-cycle pulse on each debounced rising edge.
- `press_code` output, 3 bits: 1–4 = lowest-index button pulsing this cycle; 0 = none.
- `multi_press` output, 1 bit: high when two or more `btn_pulse` bits are high in the same cycle.

## Operation
- Each channel passes through a 2-flop synchroniser, then a 4-state debounce FSM.
- FSM states and transitions (`s` = synchronised input):
  - LOW: level 0. If `s`=1, go to CHK_HIGH and clear the counter.
  - CHK_HIGH: level 0. If `s`=0, return to LOW and clear the counter. If `s`=1 and counter = `DEBOUNCE_CYCLES`-1, go to HIGH and assert the pulse. Otherwise increment the counter.
  - HIGH: level 1. If `s`=0, go to CHK_LOW and clear the counter.
  - CHK_LOW: level 1. If `s`=1, return to HIGH. If `s`=0 and counter = `DEBOUNCE_CYCLES`-1, go to LOW with no pulse. Otherwise increment.
- Counter width is clog2(`DEBOUNCE_CYCLES`+1) bits. The counter never wraps: it is cleared on every FSM transition.
- Glitches shorter than `DEBOUNCE_CYCLES` synchronised cycles produce no level change and no pulse.
- `btn_pulse` is registered. It is high only in the single cycle in which `btn_level` first reads 1.
- `press_code` and `multi_press` are combinational from the registered `btn_pulse`:
  - Lowest index wins, e.g. pulses 4'b0110 give `press_code`=2 and `multi_press`=1.
- Channels are independent. Holding one button does not block another button's pulse.
- Reset values: all synchroniser flops 0, all FSMs in LOW, counters 0, `btn_level`=0, `btn_pulse`=0, `press_code`=0, `multi_press`=0.
- Reset asserted mid-operation (CHK_* or HIGH) abandons the check immediately; no pulse is produced.
- A button held through reset release is treated as a new press. It yields one pulse after the full latency.

## Timing
- Let edge E0 be the first clock edge sampling `btn_raw`[i]=1, with the input held high from then on.
- `btn_level`[i] and `btn_pulse`[i] become 1 after edge E0+2+`DEBOUNCE_CYCLES`.
  - 2 cycles are the synchroniser; `DEBOUNCE_CYCLES` cycles are in CHK_HIGH.
- `btn_pulse`[i] returns to 0 after the following edge.
- Release latency is identical: `btn_level` falls after edge E0+2+`DEBOUNCE_CYCLES` from the first edge sampling 0.
- `press_code` and `multi_press` are valid in the same cycle as `btn_pulse`, with zero added latency.
- A button bouncing in CHK_HIGH restarts the full `DEBOUNCE_CYCLES` count from its next high sample.
- With `DEBOUNCE_CYCLES`=1, the CHK state lasts exactly one cycle.

## Structure
- Shared package: debounce state encoding (LOW, CHK_HIGH, HIGH, CHK_LOW as 2-bit constants) and the channel count of 4.
- One sub-module, `debounce_channel`: synchroniser, FSM, counter, level and pulse for one bit. It is parameterised by `DEBOUNCE_CYCLES`.
- The top instantiates four channels and adds the priority encoder and popcount≥2 logic.

## Test plan
Run all scenarios with `DEBOUNCE_CYCLES`=4.
- Reset held, then released with all inputs 0 → all outputs 0 for 20 cycles.
- `btn_raw`=4'b0100 from E0, held → `btn_level`[2] rises after E6; `btn_pulse`=4'b0100 and `press_code`=3 for exactly one cycle; `multi_press`=0.
- Bit 0 high for 3 cycles, low for 1, then high and held → no pulse until 6 cycles after the second rise; exactly one pulse, `press_code`=1.
- Bits 1 and 3 rise on the same edge → single cycle with pulse 4'b1010, `press_code`=2, `multi_press`=1.
- Button 4 held, then released, with a 2-cycle low glitch during hold → no second pulse; level stays 1 through the glitch; level falls 6 cycles after the final release.
- Reset asserted during CHK_HIGH of button 2, with the input still held → outputs 0 immediately; after release, one pulse 6 cycles later with `press_code`=2.

Source files
------------

// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the button conditioner.
// - debounce_state_e : 2-bit encoding of the per-channel debounce FSM
// - NUM_BUTTONS      : number of player buttons handled by the block
// - lowest_press_code: maps a pulse vector to the 1-based index of its
//                      lowest set bit, or 0 when no bit is set
package button_conditioner_pkg;

  localparam int unsigned NUM_BUTTONS = 4;

  typedef enum logic [1:0] {
    ST_LOW      = 2'd0,
    ST_CHK_HIGH = 2'd1,
    ST_HIGH     = 2'd2,
    ST_CHK_LOW  = 2'd3
  } debounce_state_e;

  // Walk from the top bit down so that the lowest set bit is the last
  // one written and therefore wins.
  function automatic logic [2:0] lowest_press_code(input logic [NUM_BUTTONS-1:0] pulses);
    lowest_press_code = '0;
    for (int i = NUM_BUTTONS - 1; i >= 0; i--) begin
      if (pulses[i]) begin
        lowest_press_code = 3'(i + 1);
      end
    end
  endfunction

endpackage

// File: rtl/button_conditioner_debounce_channel.sv
// One button channel: 2-flop synchroniser, 4-state debounce FSM with a
// stability counter, registered debounced level and a one-cycle pulse on
// each accepted rising edge.
// Ports:
//   clk       - system clock
//   reset     - asynchronous, active-high
//   btn_raw   - raw asynchronous button input (active-high)
//   btn_level - debounced level
//   btn_pulse - one-cycle pulse in the first cycle btn_level reads 1
module debounce_channel
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_pulse
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic            sync1_q, sync1_d;
  logic            sync2_q, sync2_d;
  debounce_state_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic            level_q, level_d;
  logic            pulse_q, pulse_d;

  logic s;
  assign s = sync2_q;

  // Next-state logic. The counter is cleared on every state change so it
  // only ever counts consecutive stable samples inside a CHK state and
  // never needs to wrap.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    pulse_d = 1'b0;

    case (state_q)
      ST_LOW: begin
        if (s) begin
          state_d = ST_CHK_HIGH;
          cnt_d   = '0;
        end
      end
      ST_CHK_HIGH: begin
        if (!s) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
          pulse_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HIGH: begin
        if (!s) begin
          state_d = ST_CHK_LOW;
          cnt_d   = '0;
        end
      end
      ST_CHK_LOW: begin
        if (s) begin
          state_d = ST_HIGH;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LOW;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = ST_LOW;
        cnt_d   = '0;
      end
    endcase

    // Level follows the state being entered, so it is registered alongside
    // the pulse and both appear in the same cycle.
    level_d = (state_d == ST_HIGH) || (state_d == ST_CHK_LOW);
  end

  // State registers; reset abandons any check in progress.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= ST_LOW;
      cnt_q   <= '0;
      level_q <= 1'b0;
      pulse_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      pulse_q <= pulse_d;
    end
  end

  assign btn_level = level_q;
  assign btn_pulse = pulse_q;

endmodule

// File: rtl/button_conditioner.sv
// Conditions the four raw player buttons for the reaction-game FSM.
// Ports:
//   clk         - system clock
//   reset       - asynchronous, active-high
//   btn_raw     - raw asynchronous buttons, bit 0 = button 1
//   btn_level   - debounced levels
//   btn_pulse   - one-cycle pulse per debounced rising edge
//   press_code  - 1..4 = lowest-index button pulsing this cycle, 0 = none
//   multi_press - two or more buttons pulsing in the same cycle
module button_conditioner
  import button_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 100_000
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NUM_BUTTONS-1:0] btn_raw,
  output logic [NUM_BUTTONS-1:0] btn_level,
  output logic [NUM_BUTTONS-1:0] btn_pulse,
  output logic [2:0]             press_code,
  output logic                   multi_press
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk      (clk),
      .reset    (reset),
      .btn_raw  (btn_raw[i]),
      .btn_level(btn_level[i]),
      .btn_pulse(btn_pulse[i])
    );
  end

  // Clearing the lowest set bit leaves something only when at least two
  // bits were set, which gives popcount >= 2 without an adder tree.
  always_comb begin
    press_code  = lowest_press_code(btn_pulse);
    multi_press = |(btn_pulse & (btn_pulse - NUM_BUTTONS'(1)));
  end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench for button_conditioner with DEBOUNCE_CYCLES = 4.
// A reference model predicts debounced levels and press events from the
// rule "a level flips once DEBOUNCE_CYCLES+1 consecutive synchronised
// samples disagree with it"; predicted press events are queued and a
// monitor compares them with what the DUT presents.
module tb_button_conditioner;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] btn_raw = 4'b0000;
  logic [3:0] btn_level;
  logic [3:0] btn_pulse;
  logic [2:0] press_code;
  logic       multi_press;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  typedef struct {
    int         cyc;
    logic [3:0] pulse;
  } exp_t;
  exp_t exp_q[$];

  logic [3:0] m_h1 = 4'b0000;
  logic [3:0] m_h2 = 4'b0000;
  logic [3:0] m_level = 4'b0000;
  int         m_run[4] = '{0, 0, 0, 0};

  button_conditioner #(
    .DEBOUNCE_CYCLES(D)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_pulse  (btn_pulse),
    .press_code (press_code),
    .multi_press(multi_press)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  function automatic logic [31:0] exp_code(input logic [3:0] p);
    for (int i = 0; i < 4; i++) begin
      if (p[i]) return 32'(i + 1);
    end
    return 32'd0;
  endfunction

  function automatic logic [31:0] exp_multi(input logic [3:0] p);
    return ($countones(p) >= 2) ? 32'd1 : 32'd0;
  endfunction

  task automatic model_clear();
    m_h1    = 4'b0000;
    m_h2    = 4'b0000;
    m_level = 4'b0000;
    for (int i = 0; i < 4; i++) m_run[i] = 0;
    exp_q.delete();
  endtask

  task automatic model_step();
    logic [3:0] s;
    logic [3:0] rise;
    s    = m_h2;
    m_h2 = m_h1;
    m_h1 = btn_raw;
    rise = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      if (s[i] != m_level[i]) begin
        m_run[i]++;
        if (m_run[i] == D + 1) begin
          m_level[i] = s[i];
          m_run[i]   = 0;
          if (s[i]) rise[i] = 1'b1;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    if (rise != 4'b0000) exp_q.push_back('{cyc: cyc, pulse: rise});
  endtask

  // Reference model advances on every clock edge; reset wipes it at once.
  always @(posedge clk) begin
    cyc++;
    if (reset) model_clear();
    else model_step();
  end

  always @(posedge reset) model_clear();

  // Monitor: compares levels every cycle and press events from the queue.
  always @(negedge clk) begin
    exp_t e;
    checkOutput("level", 32'(btn_level), 32'(m_level));
    while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
      e = exp_q.pop_front();
      checkOutput("missed_press", 32'd0, 32'(e.pulse));
    end
    if (btn_pulse !== 4'b0000) begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checkOutput("pulse", 32'(btn_pulse), 32'(e.pulse));
        checkOutput("press_code", 32'(press_code), exp_code(e.pulse));
        checkOutput("multi_press", 32'(multi_press), exp_multi(e.pulse));
      end else begin
        checkOutput("unexpected_pulse", 32'(btn_pulse), 32'd0);
      end
    end else begin
      if (exp_q.size() > 0 && exp_q[0].cyc == cyc) begin
        e = exp_q.pop_front();
        checkOutput("missed_pulse", 32'd0, 32'(e.pulse));
      end
      checkOutput("idle_code", {28'd0, press_code, multi_press}, 32'd0);
    end
  end

  task automatic applyStimulus(input logic [3:0] raw, input int cycles);
    btn_raw = raw;
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  // Called right after new inputs are driven: the next edge is E0, the
  // press must appear after E0+2+D and last exactly one cycle.
  task automatic expectPress(input logic [3:0] pulse, input int code, input int multi);
    repeat (2 + D) @(posedge clk);
    #1;
    checkOutput("pre_press_pulse", 32'(btn_pulse), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("press_pulse", 32'(btn_pulse), 32'(pulse));
    checkOutput("press_level", 32'(btn_level & pulse), 32'(pulse));
    checkOutput("press_code_dir", 32'(press_code), 32'(code));
    checkOutput("press_multi_dir", 32'(multi_press), 32'(multi));
    @(posedge clk);
    #1;
    checkOutput("post_press_pulse", 32'(btn_pulse), 32'd0);
  endtask

  initial begin
    $display("[TB] start, DEBOUNCE_CYCLES=%0d", D);

    // Reset held, then released with all inputs low.
    reset = 1'b1;
    repeat (5) @(posedge clk);
    #2;
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      checkOutput("idle_after_reset", {24'd0, btn_level, btn_pulse, press_code, multi_press}, 32'd0);
    end

    // Single press of button 3.
    btn_raw = 4'b0100;
    expectPress(4'b0100, 3, 0);
    applyStimulus(4'b0000, 12);

    // Bounce on button 1 before a clean hold.
    applyStimulus(4'b0001, 3);
    applyStimulus(4'b0000, 1);
    btn_raw = 4'b0001;
    expectPress(4'b0001, 1, 0);
    applyStimulus(4'b0000, 12);

    // Buttons 2 and 4 together.
    btn_raw = 4'b1010;
    expectPress(4'b1010, 2, 1);
    applyStimulus(4'b0000, 12);

    // Button 4 held with a short low glitch, then released.
    btn_raw = 4'b1000;
    expectPress(4'b1000, 4, 0);
    applyStimulus(4'b1000, 5);
    applyStimulus(4'b0000, 2);
    applyStimulus(4'b1000, 10);
    checkOutput("glitch_level_held", 32'(btn_level), 32'h8);
    btn_raw = 4'b0000;
    repeat (2 + D) @(posedge clk);
    #1;
    checkOutput("release_level_before", 32'(btn_level), 32'h8);
    @(posedge clk);
    #1;
    checkOutput("release_level_after", 32'(btn_level), 32'h0);
    applyStimulus(4'b0000, 6);

    // Reset while button 2 is in its high check, button still held.
    btn_raw = 4'b0010;
    repeat (4) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("reset_mid_check", {24'd0, btn_level, btn_pulse, press_code, multi_press}, 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    expectPress(4'b0010, 2, 0);
    applyStimulus(4'b0000, 12);

    // Randomised traffic: slow toggles, occasional whole-vector jumps
    // (simultaneous edges) and rare resets.
    for (int n = 0; n < 3000; n++) begin
      logic [3:0] nxt;
      nxt = btn_raw;
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(11) == 0) nxt[b] = ~nxt[b];
      end
      if ($urandom_range(39) == 0) nxt = 4'($urandom_range(15));
      btn_raw = nxt;
      if ($urandom_range(599) == 0) reset = 1'b1;
      else reset = 1'b0;
      @(posedge clk);
      #1;
    end
    reset = 1'b0;
    applyStimulus(4'b0000, 20);
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
